// File: rtl/pipe_skid_stage_pkg.sv
// rtl/pipe_skid_stage_pkg.sv - shared constants and bundle type for the pipeline skid stage
package pipe_skid_stage_pkg;

  localparam int PKG_PC_W   = 64;
  localparam int PKG_INST_W = 32;
  localparam int PKG_REG_AW = 5;
  localparam int PKG_DATA_W = 64;
  localparam int PKG_SIDE_W = 8;

  // pc shown on the output while the stage holds a bubble
  localparam logic [PKG_PC_W-1:0] ZERO_PC = '0;

  // addi x0,x0,0 : canonical nop shown on the output while the stage holds a bubble
  localparam logic [31:0] NONE_INST = 32'h0000_0013;

  // writeback bundle at default widths; the stage itself packs the same fields flat
  // (pc in the msbs, side in the lsbs) so that widths stay parametrisable
  typedef struct packed {
    logic [PKG_PC_W-1:0]   pc;
    logic [PKG_INST_W-1:0] instr;
    logic                  w_ena;
    logic [PKG_REG_AW-1:0] w_addr;
    logic [PKG_DATA_W-1:0] w_data;
    logic [PKG_SIDE_W-1:0] side;
  } stage_bundle_t;

endpackage

// File: rtl/pipe_skid_entry.sv
// rtl/pipe_skid_entry.sv - single valid+payload register with load and clear
module pipe_skid_entry
  import pipe_skid_stage_pkg::*;
#(
  parameter int W = $bits(stage_bundle_t)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // clear wins over load; clear only drops valid so the payload keeps its last value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline register with optional skid entry; PIPE_STAGE_PERF_EN adds stall/bubble counters
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int REG_AW = 5,
  parameter int DATA_W = 64,
  parameter int SIDE_W = 8,
  parameter bit SKID   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_instr,
  input  logic              in_w_ena,
  input  logic [REG_AW-1:0] in_w_addr,
  input  logic [DATA_W-1:0] in_w_data,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_instr,
  output logic              out_w_ena,
  output logic [REG_AW-1:0] out_w_addr,
  output logic [DATA_W-1:0] out_w_data,
  output logic [SIDE_W-1:0] out_side
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  // flat bundle layout, lsb first: side, w_data, w_addr, w_ena, instr, pc
  localparam int SIDE_LO  = 0;
  localparam int DATA_LO  = SIDE_LO + SIDE_W;
  localparam int ADDR_LO  = DATA_LO + DATA_W;
  localparam int ENA_BIT  = ADDR_LO + REG_AW;
  localparam int INSTR_LO = ENA_BIT + 1;
  localparam int PC_LO    = INSTR_LO + INST_W;
  localparam int BW       = PC_LO + PC_W;

  logic [BW-1:0] in_bundle;
  logic [BW-1:0] main_d;
  logic [BW-1:0] main_q;
  logic [BW-1:0] skid_q;
  logic          main_valid;
  logic          skid_valid;
  logic          accept;
  logic          retire;
  logic          main_load;
  logic          main_clear;

  assign in_bundle = {in_pc, in_instr, in_w_ena, in_w_addr, in_w_data, in_side};

  // a beat offered during flush is dropped even when in_ready is high
  assign accept = in_valid & in_ready & ~flush;
  assign retire = main_valid & out_ready;

  // main refills from skid when draining TWO, otherwise from the input when it is free or retiring
  assign main_load  = (skid_valid & retire) | (accept & (~main_valid | retire));
  assign main_clear = flush | (retire & ~skid_valid & ~accept);
  assign main_d     = skid_valid ? skid_q : in_bundle;

  pipe_skid_entry #(.W(BW)) u_main (
    .clock (clock),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  if (SKID) begin : g_skid
    logic skid_load;
    logic skid_clear;

    // skid only catches a beat when main is held; in_ready is derived straight from a flop
    assign skid_load  = accept & main_valid & ~retire;
    assign skid_clear = flush | retire;
    assign in_ready   = ~skid_valid;

    pipe_skid_entry #(.W(BW)) u_skid (
      .clock (clock),
      .reset (reset),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_bundle),
      .valid (skid_valid),
      .q     (skid_q)
    );
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_q     = '0;
    assign in_ready   = out_ready | ~main_valid;
  end

  // bubbles present a nop at pc zero; addr, data and side keep their last value
  assign out_valid  = main_valid;
  assign out_pc     = main_valid ? main_q[PC_LO +: PC_W]      : PC_W'(ZERO_PC);
  assign out_instr  = main_valid ? main_q[INSTR_LO +: INST_W] : INST_W'(NONE_INST);
  assign out_w_ena  = main_valid & main_q[ENA_BIT];
  assign out_w_addr = main_q[ADDR_LO +: REG_AW];
  assign out_w_data = main_q[DATA_LO +: DATA_W];
  assign out_side   = main_q[SIDE_LO +: SIDE_W];

`ifdef PIPE_STAGE_PERF_EN
  // free-running wrap-around counters, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (main_valid & ~out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (!main_valid) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - directed self-checking bench for pipe_skid_stage (SKID=1 and SKID=0 instances)
module tb_pipe_skid_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        d0_in_valid = 1'b0;
  logic        d0_out_ready = 1'b0;
  logic [63:0] in_pc = '0;
  logic [31:0] in_instr = 32'h00a0_0093;
  logic        in_w_ena = 1'b1;
  logic [4:0]  in_w_addr = 5'd3;
  logic [63:0] in_w_data = '0;
  logic [7:0]  in_side = 8'h5a;

  logic        in_ready, out_valid, out_w_ena;
  logic [63:0] out_pc, out_w_data;
  logic [31:0] out_instr;
  logic [4:0]  out_w_addr;
  logic [7:0]  out_side;

  logic        d0_in_ready, d0_out_valid, d0_out_w_ena;
  logic [63:0] d0_out_pc, d0_out_w_data;
  logic [31:0] d0_out_instr;
  logic [4:0]  d0_out_w_addr;
  logic [7:0]  d0_out_side;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt, d0_perf_stall_cnt, d0_perf_bubble_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  pipe_skid_stage #(.SKID(1'b1)) u_dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_w_ena(in_w_ena),
    .in_w_addr(in_w_addr), .in_w_data(in_w_data), .in_side(in_side),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_w_ena(out_w_ena),
    .out_w_addr(out_w_addr), .out_w_data(out_w_data), .out_side(out_side)
`ifdef PIPE_STAGE_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  pipe_skid_stage #(.SKID(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(d0_in_valid), .in_ready(d0_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_w_ena(in_w_ena),
    .in_w_addr(in_w_addr), .in_w_data(in_w_data), .in_side(in_side),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready),
    .out_pc(d0_out_pc), .out_instr(d0_out_instr), .out_w_ena(d0_out_w_ena),
    .out_w_addr(d0_out_w_addr), .out_w_data(d0_out_w_data), .out_side(d0_out_side)
`ifdef PIPE_STAGE_PERF_EN
    , .perf_stall_cnt(d0_perf_stall_cnt), .perf_bubble_cnt(d0_perf_bubble_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [63:0] pc, input logic [63:0] data);
    in_valid  = 1'b1;
    in_pc     = pc;
    in_w_data = data;
  endtask

  initial begin
    // reset state, before any clock edge
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 64'h13);
    check("rst_out_w_ena", out_w_ena, 0);
    check("rst_out_w_data", out_w_data, 0);
    check("rst_out_side", out_side, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_d0_in_ready", d0_in_ready, 1);
    tick();
    tick();
    reset = 1'b1;

    // back-to-back with out_ready high
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      beat(64'h8000_0000 + 64'(4 * k), 64'ha0 + 64'(k));
      tick();
      check("b2b_valid", out_valid, 1);
      check("b2b_pc", out_pc, 64'h8000_0000 + 64'(4 * k));
      check("b2b_in_ready", in_ready, 1);
    end
    check("b2b_w_ena", out_w_ena, 1);
    check("b2b_w_addr", out_w_addr, 3);
    in_valid = 1'b0;
    tick();
    check("bubble_valid", out_valid, 0);
    check("bubble_pc", out_pc, 0);
    check("bubble_instr", out_instr, 64'h13);
    check("bubble_w_ena", out_w_ena, 0);
    check("bubble_data_hold", out_w_data, 64'ha2);
    check("bubble_side_hold", out_side, 64'h5a);

    // skid fill and drain
    out_ready = 1'b0;
    beat(64'h100, 64'h11);
    tick();
    check("fill_a_valid", out_valid, 1);
    check("fill_a_in_ready", in_ready, 1);
    beat(64'h104, 64'h22);
    tick();
    check("fill_b_in_ready", in_ready, 0);
    check("fill_b_hold_data", out_w_data, 64'h11);
    check("fill_b_hold_pc", out_pc, 64'h100);
    beat(64'h108, 64'h33);
    tick();
    check("full_hold_data", out_w_data, 64'h11);
    check("full_in_ready", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("drain_b_pc", out_pc, 64'h104);
    check("drain_b_data", out_w_data, 64'h22);
    check("drain_b_in_ready", in_ready, 1);
    tick();
    check("drain_done_valid", out_valid, 0);
    check("drain_done_in_ready", in_ready, 1);
    check("drain_done_data", out_w_data, 64'h22);

    // flush with full skid
    out_ready = 1'b0;
    beat(64'h200, 64'h44);
    tick();
    beat(64'h204, 64'h55);
    tick();
    check("flush_pre_in_ready", in_ready, 0);
    flush = 1'b1;
    beat(64'h208, 64'h66);
    tick();
    check("flush_valid", out_valid, 0);
    check("flush_w_ena", out_w_ena, 0);
    check("flush_in_ready", in_ready, 1);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("flush_no_c", out_valid, 0);

    // flush discards a beat even while in_ready is high
    beat(64'h300, 64'h77);
    tick();
    check("flush1_pre_valid", out_valid, 1);
    flush = 1'b1;
    beat(64'h304, 64'h88);
    tick();
    check("flush1_valid", out_valid, 0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("flush1_dropped", out_valid, 0);

    // asynchronous reset mid-stream
    out_ready = 1'b1;
    beat(64'h8000_0000, 64'h99);
    tick();
    check("mid_pre_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_pc", out_pc, 0);
    check("mid_rst_instr", out_instr, 64'h13);
    check("mid_rst_w_ena", out_w_ena, 0);
    check("mid_rst_w_data", out_w_data, 0);
    #1 reset = 1'b1;
    tick();
    check("mid_post_valid", out_valid, 1);
    check("mid_post_pc", out_pc, 64'h8000_0000);
    in_valid = 1'b0;
    tick();

    // SKID=0 instance: combinational in_ready, no bubble on reload
    d0_out_ready = 1'b0;
    d0_in_valid  = 1'b1;
    in_pc        = 64'h400;
    tick();
    check("d0_valid", d0_out_valid, 1);
    check("d0_stall_in_ready", d0_in_ready, 0);
    d0_out_ready = 1'b1;
    #1;
    check("d0_go_in_ready", d0_in_ready, 1);
    in_pc = 64'h404;
    tick();
    check("d0_reload_valid", d0_out_valid, 1);
    check("d0_reload_pc", d0_out_pc, 64'h404);
    d0_in_valid = 1'b0;
    tick();
    check("d0_empty_valid", d0_out_valid, 0);

`ifdef PIPE_STAGE_PERF_EN
    // counters: 1 bubble before load, 5 stalls, 1 retire, 3 idle, then a flush cycle
    out_ready = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    beat(64'h500, 64'haa);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("perf_stall_5", perf_stall_cnt, 5);
    out_ready = 1'b1;
    tick();
    repeat (3) tick();
    check("perf_bubble_4", perf_bubble_cnt, 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("perf_flush_stall", perf_stall_cnt, 5);
    check("perf_flush_bubble", perf_bubble_cnt, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
